// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial adder controller: streams two W-bit operands through an external 4-bit adder.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
module nibble_serial_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   op_a,
    input  logic [4*NIBBLES-1:0]   op_b,
    input  logic                   cin,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   cout,
    output logic [3:0]             add_a,
    output logic [3:0]             add_b,
    output logic                   add_c0,
`ifdef SERIAL_ADD_OVF_EN
    output logic                   ovf,
`endif
    input  logic [3:0]             add_f,
    input  logic                   add_c4
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_sh_q, a_sh_d;
    logic [W-1:0]    b_sh_q, b_sh_d;
    logic [W-1:0]    s_sh_q, s_sh_d;
    logic            cr_q, cr_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_sh_q  <= '0;
            cr_q    <= 1'b0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            s_sh_q  <= s_sh_d;
            cr_q    <= cr_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        s_sh_d  = s_sh_q;
        cr_d    = cr_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = op_a;
                    b_sh_d  = op_b;
                    cr_d    = cin;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Each sum nibble enters at the top, so after NIBBLES shifts nibble 0 sits at the bottom.
                s_sh_d = W'({add_f, s_sh_q} >> 4);
                a_sh_d = a_sh_q >> 4;
                b_sh_d = b_sh_q >> 4;
                cr_d   = add_c4;
                idx_d  = idx_q + IW'(1);
                if (idx_q == LAST_IDX) begin
                    sum_d   = s_sh_d;
                    cout_d  = add_c4;
                    ovf_d   = (a_sh_q[3] == b_sh_q[3]) && (add_f[3] != a_sh_q[3]);
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        add_a  = 4'h0;
        add_b  = 4'h0;
        add_c0 = 1'b0;
        if (state_q == RUN) begin
            add_a  = a_sh_q[3:0];
            add_b  = b_sh_q[3:0];
            add_c0 = cr_q;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf  = ovf_q;
`else
    // Without the overflow port the flop has no reader; keep it tied low so it trims away.
    logic unused_ovf;
    assign unused_ovf = ovf_q & ovf_d & 1'b0;
`endif

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Randomised self-checking bench for nibble_serial_add_ctrl with a behavioural 4-bit adder attached.
// Define SERIAL_ADD_OVF_EN to also check the signed-overflow output.
module tb_nibble_serial_add_ctrl;

    localparam int NIBBLES = 4;
    localparam int W = 4 * NIBBLES;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] op_a, op_b;
    logic         cin;
    logic         busy, done, cout;
    logic [W-1:0] sum;
    logic [3:0]   add_a, add_b, add_f;
    logic         add_c0, add_c4;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign {add_c4, add_f} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_c0};

    nibble_serial_add_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op_a   (op_a),
        .op_b   (op_b),
        .cin    (cin),
        .busy   (busy),
        .done   (done),
        .sum    (sum),
        .cout   (cout),
        .add_a  (add_a),
        .add_b  (add_b),
        .add_c0 (add_c0),
`ifdef SERIAL_ADD_OVF_EN
        .ovf    (ovf),
`endif
        .add_f  (add_f),
        .add_c4 (add_c4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: full-width sum {cout, sum} = a + b + cin.
    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        logic [W:0] r;
        r = ref_add(a, b, c);
        return (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
    endfunction

    // Launch one operation and wait (bounded) for done; optionally scramble inputs after the start edge.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input bit scramble, output int lat, output bit busy_ok);
        op_a = a; op_b = b; cin = c; start = 1'b1;
        tick();
        start = 1'b0;
        if (scramble) begin
            op_a = W'($urandom);
            op_b = W'($urandom);
            cin  = 1'($urandom);
        end
        lat = 0;
        busy_ok = 1'b1;
        while (!done && lat < 20) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            tick();
            lat++;
        end
        if (busy !== 1'b0) busy_ok = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0; cin = 1'b0;
        tick();
        tick();
        tests++;
        if ({busy, done, sum, cout, add_a, add_b, add_c0} !== '0) begin
            fails++;
            $display("[TB] FAIL reset_state: got busy=%b done=%b sum=%h cout=%b add_a=%h add_b=%h add_c0=%b, want all zero",
                     busy, done, sum, cout, add_a, add_b, add_c0);
        end
`ifdef SERIAL_ADD_OVF_EN
        tests++;
        if (ovf !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_ovf: got %b want 0", ovf);
        end
`endif
        rst = 1'b0;
        tick();
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [4] = '{16'h1234, 16'hFFFF, 16'hFFFF, 16'h0000};
        logic [W-1:0] tb [4] = '{16'h4321, 16'h0001, 16'h0000, 16'h0000};
        logic         tc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [W:0]   exp;
        int           lat;
        bit           busy_ok;
        for (int i = 0; i < 4; i++) begin
            run_op(ta[i], tb[i], tc[i], 1'b0, lat, busy_ok);
            exp = ref_add(ta[i], tb[i], tc[i]);
            tests++;
            if (lat !== NIBBLES) begin
                fails++;
                $display("[TB] FAIL directed_latency[%0d]: got %0d cycles want %0d", i, lat, NIBBLES);
            end
            tests++;
            if ({cout, sum} !== exp) begin
                fails++;
                $display("[TB] FAIL directed_result[%0d]: got cout=%b sum=%h want cout=%b sum=%h",
                         i, cout, sum, exp[W], exp[W-1:0]);
            end
            tests++;
            if (!busy_ok) begin
                fails++;
                $display("[TB] FAIL directed_busy[%0d]: busy not high through RUN and low at done", i);
            end
            tick();
            tests++;
            if (done !== 1'b0 || {cout, sum} !== exp) begin
                fails++;
                $display("[TB] FAIL directed_hold[%0d]: got done=%b cout=%b sum=%h want done=0 cout=%b sum=%h",
                         i, done, cout, sum, exp[W], exp[W-1:0]);
            end
        end
    endtask

    task automatic test_nibble_drive();
        logic [W-1:0] a, b;
        logic         c;
        int           carry;
        int           mask;
        a = W'($urandom); b = W'($urandom); c = 1'($urandom);
        op_a = a; op_b = b; cin = c; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < NIBBLES; k++) begin
            mask  = (1 << (4 * k)) - 1;
            carry = ((int'(a) & mask) + (int'(b) & mask) + int'(c)) >> (4 * k);
            tests++;
            if (add_a !== a[4*k +: 4] || add_b !== b[4*k +: 4] || add_c0 !== carry[0]) begin
                fails++;
                $display("[TB] FAIL nibble_drive[%0d]: got a=%h b=%h c0=%b want a=%h b=%h c0=%b",
                         k, add_a, add_b, add_c0, a[4*k +: 4], b[4*k +: 4], carry[0]);
            end
            tick();
        end
        tests++;
        if (done !== 1'b1 || {add_a, add_b, add_c0} !== '0) begin
            fails++;
            $display("[TB] FAIL idle_drive: got done=%b a=%h b=%h c0=%b want done=1 and zero drive",
                     done, add_a, add_b, add_c0);
        end
        tick();
    endtask

    task automatic test_start_during_run();
        logic [W-1:0] prev;
        logic [W:0]   exp;
        int           lat;
        bit           busy_ok;
        prev = sum;
        exp = ref_add(16'h0F0F, 16'h1111, 1'b1);
        op_a = 16'h0F0F; op_b = 16'h1111; cin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tests++;
        if (sum !== prev) begin
            fails++;
            $display("[TB] FAIL hold_at_start: got sum=%h want %h", sum, prev);
        end
        tick();
        op_a = 16'hAAAA; op_b = 16'h5555; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 2;
        busy_ok = 1'b1;
        while (!done && lat < 20) begin
            if (busy !== 1'b1 || sum !== prev) busy_ok = 1'b0;
            tick();
            lat++;
        end
        tests++;
        if (lat !== NIBBLES || {cout, sum} !== exp || !busy_ok) begin
            fails++;
            $display("[TB] FAIL start_in_run: got lat=%0d cout=%b sum=%h busy_ok=%b want lat=%0d cout=%b sum=%h busy_ok=1",
                     lat, cout, sum, busy_ok, NIBBLES, exp[W], exp[W-1:0]);
        end
        tick();
        tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("[TB] FAIL start_in_run_idle: got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_reset_mid();
        int  lat;
        bit  busy_ok;
        bit  saw_done;
        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, lat, busy_ok);
        tick();
        op_a = 16'h8888; op_b = 16'h9999; cin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        tests++;
        if ({busy, done, sum, cout, add_a, add_b, add_c0} !== '0) begin
            fails++;
            $display("[TB] FAIL reset_mid: got busy=%b done=%b sum=%h cout=%b a=%h b=%h c0=%b want all zero",
                     busy, done, sum, cout, add_a, add_b, add_c0);
        end
        rst = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
        end
        tests++;
        if (saw_done) begin
            fails++;
            $display("[TB] FAIL reset_abandon: got done/busy activity after reset, want none");
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a1, b1, a2, b2;
        logic         c1, c2;
        logic [W:0]   e1, e2;
        int           lat;
        a1 = W'($urandom); b1 = W'($urandom); c1 = 1'($urandom);
        a2 = W'($urandom); b2 = W'($urandom); c2 = 1'($urandom);
        e1 = ref_add(a1, b1, c1);
        e2 = ref_add(a2, b2, c2);
        op_a = a1; op_b = b1; cin = c1; start = 1'b1;
        tick();
        op_a = a2; op_b = b2; cin = c2;
        lat = 0;
        while (!done && lat < 20) begin tick(); lat++; end
        tests++;
        if (lat !== NIBBLES || {cout, sum} !== e1) begin
            fails++;
            $display("[TB] FAIL b2b_first: got lat=%0d cout=%b sum=%h want lat=%0d cout=%b sum=%h",
                     lat, cout, sum, NIBBLES, e1[W], e1[W-1:0]);
        end
        tick();
        start = 1'b0;
        lat = 1;
        while (!done && lat < 20) begin tick(); lat++; end
        tests++;
        if (lat !== NIBBLES + 1 || {cout, sum} !== e2) begin
            fails++;
            $display("[TB] FAIL b2b_second: got interval=%0d cout=%b sum=%h want interval=%0d cout=%b sum=%h",
                     lat, cout, sum, NIBBLES + 1, e2[W], e2[W-1:0]);
        end
        tick();
    endtask

    task automatic test_random();
        logic [W-1:0] a, b;
        logic         c;
        logic [W:0]   exp;
        int           lat;
        bit           busy_ok;
        int           bad;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            a = W'($urandom); b = W'($urandom); c = 1'($urandom);
            if (i % 8 == 0) b = ~a;
            run_op(a, b, c, 1'b1, lat, busy_ok);
            exp = ref_add(a, b, c);
            tests++;
            if (lat !== NIBBLES || {cout, sum} !== exp || !busy_ok) begin
                fails++;
                bad++;
                if (bad < 5)
                    $display("[TB] FAIL random[%0d] %h+%h+%b: got lat=%0d cout=%b sum=%h want lat=%0d cout=%b sum=%h",
                             i, a, b, c, lat, cout, sum, NIBBLES, exp[W], exp[W-1:0]);
            end
`ifdef SERIAL_ADD_OVF_EN
            tests++;
            if (ovf !== ref_ovf(a, b, c)) begin
                fails++;
                $display("[TB] FAIL random_ovf[%0d]: got %b want %b", i, ovf, ref_ovf(a, b, c));
            end
`endif
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
        end
    endtask

`ifdef SERIAL_ADD_OVF_EN
    task automatic test_ovf();
        logic [W-1:0] ta [3] = '{16'h7FFF, 16'h8000, 16'h0001};
        logic [W-1:0] tb [3] = '{16'h0001, 16'hFFFF, 16'hFFFF};
        logic         eo [3] = '{1'b1, 1'b1, 1'b0};
        logic [W:0]   exp;
        int           lat;
        bit           busy_ok;
        for (int i = 0; i < 3; i++) begin
            run_op(ta[i], tb[i], 1'b0, 1'b0, lat, busy_ok);
            exp = ref_add(ta[i], tb[i], 1'b0);
            tests++;
            if (ovf !== eo[i] || {cout, sum} !== exp) begin
                fails++;
                $display("[TB] FAIL ovf[%0d]: got ovf=%b cout=%b sum=%h want ovf=%b cout=%b sum=%h",
                         i, ovf, cout, sum, eo[i], exp[W], exp[W-1:0]);
            end
            tick();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_nibble_drive();
        test_start_during_run();
        test_back_to_back();
        test_random();
`ifdef SERIAL_ADD_OVF_EN
        test_ovf();
`endif
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
